// File: rtl/serial_byte_loader_pkg.sv
// Shared types and constants for the serial byte loader: FSM state encodings,
// default frame width and the bit counter width derivation.
package serial_byte_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter must be able to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in shift register that assembles one frame; the direction is set by
// MSB_FIRST, and clr empties it at the start of a frame or on abort.
module serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    // MSB-first frames enter at the LSB and walk upward; LSB-first frames do the opposite.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign q_next = {q[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign q_next = {sin, q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/serial_byte_loader.sv
// Assembles a serially delivered frame and presents it with a one-cycle load strobe
// for the downstream latch. Define LOADER_PARITY_EN to add an even-parity check bit.
module serial_byte_loader
    import serial_byte_loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         sin_valid,
    input  logic                         sin,
    input  logic                         clear,
    output logic [WIDTH-1:0]             d_out,
    output logic                         load_en,
    output logic                         busy,
    output logic [cnt_width(WIDTH)-1:0]  bit_cnt
`ifdef LOADER_PARITY_EN
    ,
    output logic                         parity_err
`endif
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             shift_en;
    logic             shreg_clr;

    assign shift_en  = (state == ST_SHIFT) && sin_valid && !clear;
    assign shreg_clr = clear || ((state == ST_IDLE) && start);

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clr      (shreg_clr),
        .shift_en (shift_en),
        .sin      (sin),
        .q        (shreg)
    );

`ifndef LOADER_PARITY_EN
    // The final bit is still on sin at the completing edge, so d_out takes the
    // shift register's next value rather than its current one.
    logic [WIDTH-1:0] assembled;

    generate
        if (MSB_FIRST) begin : g_asm_msb
            assign assembled = {shreg[WIDTH-2:0], sin};
        end else begin : g_asm_lsb
            assign assembled = {sin, shreg[WIDTH-1:1]};
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            d_out   <= '0;
            load_en <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
`ifdef LOADER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            load_en <= 1'b0;
`ifdef LOADER_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (clear) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (sin_valid) begin
                            if (bit_cnt == LAST_BIT) begin
`ifdef LOADER_PARITY_EN
                                state   <= ST_PARITY;
                                bit_cnt <= bit_cnt + CW'(1);
`else
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                                bit_cnt <= '0;
                                d_out   <= assembled;
                                load_en <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
`ifdef LOADER_PARITY_EN
                    // Even parity: the data bits together with the parity bit must XOR to zero.
                    ST_PARITY: begin
                        if (sin_valid) begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                            if (^{shreg, sin} == 1'b0) begin
                                d_out   <= shreg;
                                load_en <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
Upstream feeder for the 8-bit D latch stage. Assembles a serially delivered byte bit by bit and presents it on a parallel bus. It raises a one-cycle load strobe that drives the latch's enable, with the parallel bus driving the latch's d input. Framing is controlled by a start pulse, with per-bit valid and a synchronous abort.

Parameters:
WIDTH, 8, number of data bits per frame (must be >= 2).
MSB_FIRST, 1, 1 = first received bit lands in d_out[WIDTH-1]; 0 = first bit lands in d_out[0].

Ports:
clk  input  1  single system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  begin a frame; sampled only in IDLE.
sin_valid  input  1  sin carries a valid bit this cycle.
sin  input  1  serial data bit.
clear  input  1  synchronous abort; returns to IDLE with no load.
d_out  output  WIDTH  last completed byte; feeds latch d.
load_en  output  1  one-cycle strobe; feeds latch enable.
busy  output  1  high while a frame is in progress.
bit_cnt  output  log2(WIDTH)+1  bits captured so far in the current frame.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, d_out=0, load_en=0, busy=0, bit_cnt=0, internal shift register=0. Reset mid-frame discards the partial frame. No load_en follows reset release.
- All outputs are registered.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- IDLE:
  - busy=0.
  - start=1 -> SHIFT; shift register and bit_cnt cleared. busy=1 from the next cycle.
  - sin_valid is ignored in IDLE, including the cycle in which start is sampled.
- SHIFT:
  - sin_valid=1 shifts sin in and increments bit_cnt.
  - MSB_FIRST=1: shift left, with new bit in at LSB.
  - MSB_FIRST=0: shift right, with new bit in at MSB.
  - sin_valid=0 stalls: nothing changes and there is no timeout.
  - start is ignored in SHIFT.
- Completion:
  - On the edge that captures bit WIDTH (bit_cnt WIDTH-1 -> WIDTH), d_out takes the fully assembled value and load_en goes to 1 on the same edge.
  - State returns to IDLE, busy=0, and bit_cnt resets to 0 on that edge.
  - load_en is high for exactly one cycle.
  - d_out holds until the next completed frame. Partial frames never alter d_out.
- Back-to-back frames: start=1 during the load_en cycle is accepted. There is no dead cycle beyond that.
- clear=1:
  - Has priority over start and sin_valid.
  - From any state: next state IDLE, bit_cnt=0, busy=0, load_en=0; d_out unchanged.
  - clear on the same edge as the final bit aborts the frame, so no load occurs.
- The block never asserts load_en while busy=1.

Optional Feature:
Macro LOADER_PARITY_EN.
- Defined:
  - After bit WIDTH, the FSM enters PARITY (busy stays 1) and waits for one more valid bit, which is the even-parity bit over the data.
  - If the XOR of the data bits and the parity bit is 0: d_out updates and load_en pulses, exactly as in the normal completion case.
  - Otherwise: d_out is unchanged, load_en stays 0, and an extra output parity_err (1 bit, reset 0) pulses for one cycle.
  - In both cases the FSM returns to IDLE.
  - clear in PARITY aborts with no pulse.
- Undefined: no PARITY state, no parity_err port; completion occurs on bit WIDTH.

Decomposition:
- Shared package/include file holds:
  - state encodings (ST_IDLE, ST_SHIFT, ST_PARITY)
  - the default WIDTH constant
  - the bit_cnt width derivation
- One sub-module: serial_shift_reg.
  - Parameterised WIDTH and MSB_FIRST.
  - Inputs: clk, reset, clr, shift_en, sin. Output: q[WIDTH-1:0].
- The top holds the FSM, bit counter, d_out register and strobes.

Test Plan:
1. Reset with reset=0 mid-frame after 3 bits, then release -> d_out=8'h00, busy=0, bit_cnt=0, and no load_en in the following 20 cycles.
2. MSB_FIRST=1, start, then bits 1,0,1,0,0,1,0,1 with sin_valid=1 every cycle -> load_en high for exactly one cycle on the 8th bit edge, d_out=8'hA5, busy=0 afterwards.
3. MSB_FIRST=0, same bit sequence with sin_valid gaps (valid pattern 1,0,0,1,...) -> d_out=8'hA5 reversed = 8'hA5 (palindrome check); repeat with bits 1,1,0,0,0,0,0,0 -> d_out=8'h03. load_en timing tracks the last valid bit, not the cycle count.
4. Frame with 8'h3C completed, then start and 5 bits followed by clear=1 -> no load_en, d_out stays 8'h3C, bit_cnt=0, busy=0.
5. Back-to-back: start asserted in the load_en cycle of frame 8'hFF, then frame 8'h01 -> two load_en pulses exactly 9 cycles apart; d_out=8'hFF then 8'h01.
6. LOADER_PARITY_EN defined: 8'hA5 with parity 0 -> load_en, d_out=8'hA5; 8'h07 with parity 0 -> parity_err pulse, no load_en, d_out stays 8'hA5.
